// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order reorder buffer sitting between dispatch, the common data
//   bus (CDB) and the register file. Each dispatched instruction receives the
//   current tail index as its tag. CDB broadcasts mark tagged entries ready.
//   The head entry retires once it is ready, at most one per cycle, through a
//   registered commit port. A conditional branch whose actual outcome differs
//   from its prediction raises a one-cycle flush (xbp) with the redirect PC
//   when it commits, and empties the buffer on the same edge.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable; low holds every register
//   in_disp_*            dispatch request (dest reg, branch flag, prediction)
//   out_disp_rob         tag the next dispatch receives (current tail)
//   out_full             no free entry; dispatch is ignored
//   in_cdb_*             result broadcast (tag, value, taken, target)
//   in_q_rob1/2          operand tag queries
//   out_q_ready1/2       queried entry has (or is receiving) its result
//   out_q_value1/2       queried result value, CDB value forwarded
//   out_commit_reg/rob/value   registered commit port, reg 0 = no write
//   out_xbp, out_xbp_pc  registered mispredict flush pulse and redirect PC

module reorder_buffer #(
   parameter int ROB_SIZE  = 16,
   parameter int ROB_POS_W = 4,
   parameter int REG_POS_W = 5,
   parameter int DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,

   input  logic                 in_disp_valid,
   input  logic [REG_POS_W-1:0] in_disp_dest_reg,
   input  logic                 in_disp_is_br,
   input  logic                 in_disp_pred,
   output logic [ROB_POS_W-1:0] out_disp_rob,
   output logic                 out_full,

   input  logic                 in_cdb_valid,
   input  logic [ROB_POS_W-1:0] in_cdb_rob,
   input  logic [DATA_W-1:0]    in_cdb_value,
   input  logic                 in_cdb_taken,
   input  logic [DATA_W-1:0]    in_cdb_target,

   input  logic [ROB_POS_W-1:0] in_q_rob1,
   input  logic [ROB_POS_W-1:0] in_q_rob2,
   output logic                 out_q_ready1,
   output logic                 out_q_ready2,
   output logic [DATA_W-1:0]    out_q_value1,
   output logic [DATA_W-1:0]    out_q_value2,

   output logic [REG_POS_W-1:0] out_commit_reg,
   output logic [ROB_POS_W-1:0] out_commit_rob,
   output logic [DATA_W-1:0]    out_commit_value,
   output logic                 out_xbp,
   output logic [DATA_W-1:0]    out_xbp_pc
);

   localparam logic [ROB_POS_W-1:0] POS_ONE  = ROB_POS_W'(1);
   localparam logic [ROB_POS_W:0]   CNT_ONE  = (ROB_POS_W+1)'(1);
   localparam logic [ROB_POS_W:0]   CNT_FULL = (ROB_POS_W+1)'(ROB_SIZE);

   logic [ROB_POS_W-1:0] r_head;
   logic [ROB_POS_W-1:0] r_tail;
   logic [ROB_POS_W:0]   r_count;

   logic                 r_busy   [ROB_SIZE];
   logic                 r_ready  [ROB_SIZE];
   logic [REG_POS_W-1:0] r_dest   [ROB_SIZE];
   logic [DATA_W-1:0]    r_value  [ROB_SIZE];
   logic                 r_is_br  [ROB_SIZE];
   logic                 r_pred   [ROB_SIZE];
   logic                 r_taken  [ROB_SIZE];
   logic [DATA_W-1:0]    r_target [ROB_SIZE];

   logic [REG_POS_W-1:0] r_commit_reg;
   logic [ROB_POS_W-1:0] r_commit_rob;
   logic [DATA_W-1:0]    r_commit_value;
   logic                 r_xbp;
   logic [DATA_W-1:0]    r_xbp_pc;

   logic                 w_full;
   logic                 w_commit;
   logic                 w_flush;
   logic                 w_disp;
   logic                 w_cdb;
   logic [ROB_POS_W:0]   w_count_nxt;
   logic                 w_fwd1;
   logic                 w_fwd2;

   assign w_full = (r_count == CNT_FULL);

   // Commit only looks at the stored ready bit; a CDB result for the head in
   // this cycle retires on the following edge.
   assign w_commit = rdy & r_busy[r_head] & r_ready[r_head];
   assign w_flush  = w_commit & r_is_br[r_head] & (r_taken[r_head] != r_pred[r_head]);

   // A flushing cycle drops the dispatch and CDB writes it would otherwise take.
   assign w_disp = rdy & in_disp_valid & ~w_full & ~w_flush;
   assign w_cdb  = rdy & in_cdb_valid & r_busy[in_cdb_rob] & ~w_flush;

   always_comb begin
      w_count_nxt = r_count;
      if (w_disp && !w_commit) begin
         w_count_nxt = r_count + CNT_ONE;
      end else if (!w_disp && w_commit) begin
         w_count_nxt = r_count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_commit_reg   <= '0;
         r_commit_rob   <= '0;
         r_commit_value <= '0;
         r_xbp          <= 1'b0;
         r_xbp_pc       <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            r_busy[i]   <= 1'b0;
            r_ready[i]  <= 1'b0;
            r_dest[i]   <= '0;
            r_value[i]  <= '0;
            r_is_br[i]  <= 1'b0;
            r_pred[i]   <= 1'b0;
            r_taken[i]  <= 1'b0;
            r_target[i] <= '0;
         end
      end else if (rdy) begin
         if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
               r_busy[i]  <= 1'b0;
               r_ready[i] <= 1'b0;
            end
         end else begin
            if (w_disp) begin
               r_busy[r_tail]  <= 1'b1;
               r_ready[r_tail] <= 1'b0;
               r_dest[r_tail]  <= in_disp_dest_reg;
               r_is_br[r_tail] <= in_disp_is_br;
               r_pred[r_tail]  <= in_disp_pred;
               r_tail          <= r_tail + POS_ONE;
            end
            if (w_cdb) begin
               r_ready[in_cdb_rob]  <= 1'b1;
               r_value[in_cdb_rob]  <= in_cdb_value;
               r_taken[in_cdb_rob]  <= in_cdb_taken;
               r_target[in_cdb_rob] <= in_cdb_target;
            end
            // Placed after the CDB write so a retiring entry always ends idle.
            if (w_commit) begin
               r_busy[r_head]  <= 1'b0;
               r_ready[r_head] <= 1'b0;
               r_head          <= r_head + POS_ONE;
            end
            r_count <= w_count_nxt;
         end

         // Branches never write the regfile, regardless of their dest field.
         if (w_commit && !r_is_br[r_head]) begin
            r_commit_reg <= r_dest[r_head];
         end else begin
            r_commit_reg <= '0;
         end
         if (w_commit) begin
            r_commit_rob   <= r_head;
            r_commit_value <= r_value[r_head];
         end
         r_xbp <= w_flush;
         if (w_flush) begin
            r_xbp_pc <= r_target[r_head];
         end
      end
   end

   assign w_fwd1 = in_cdb_valid & (in_cdb_rob == in_q_rob1);
   assign w_fwd2 = in_cdb_valid & (in_cdb_rob == in_q_rob2);

   assign out_q_ready1 = r_ready[in_q_rob1] | w_fwd1;
   assign out_q_ready2 = r_ready[in_q_rob2] | w_fwd2;
   assign out_q_value1 = w_fwd1 ? in_cdb_value : r_value[in_q_rob1];
   assign out_q_value2 = w_fwd2 ? in_cdb_value : r_value[in_q_rob2];

   assign out_disp_rob     = r_tail;
   assign out_full         = w_full;
   assign out_commit_reg   = r_commit_reg;
   assign out_commit_rob   = r_commit_rob;
   assign out_commit_value = r_commit_value;
   assign out_xbp          = r_xbp;
   assign out_xbp_pc       = r_xbp_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        in_disp_valid;
   logic [4:0]  in_disp_dest_reg;
   logic        in_disp_is_br;
   logic        in_disp_pred;
   logic [3:0]  out_disp_rob;
   logic        out_full;
   logic        in_cdb_valid;
   logic [3:0]  in_cdb_rob;
   logic [31:0] in_cdb_value;
   logic        in_cdb_taken;
   logic [31:0] in_cdb_target;
   logic [3:0]  in_q_rob1;
   logic [3:0]  in_q_rob2;
   logic        out_q_ready1;
   logic        out_q_ready2;
   logic [31:0] out_q_value1;
   logic [31:0] out_q_value2;
   logic [4:0]  out_commit_reg;
   logic [3:0]  out_commit_rob;
   logic [31:0] out_commit_value;
   logic        out_xbp;
   logic [31:0] out_xbp_pc;

   int n_chk  = 0;
   int n_pass = 0;

   reorder_buffer dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .in_disp_valid    (in_disp_valid),
      .in_disp_dest_reg (in_disp_dest_reg),
      .in_disp_is_br    (in_disp_is_br),
      .in_disp_pred     (in_disp_pred),
      .out_disp_rob     (out_disp_rob),
      .out_full         (out_full),
      .in_cdb_valid     (in_cdb_valid),
      .in_cdb_rob       (in_cdb_rob),
      .in_cdb_value     (in_cdb_value),
      .in_cdb_taken     (in_cdb_taken),
      .in_cdb_target    (in_cdb_target),
      .in_q_rob1        (in_q_rob1),
      .in_q_rob2        (in_q_rob2),
      .out_q_ready1     (out_q_ready1),
      .out_q_ready2     (out_q_ready2),
      .out_q_value1     (out_q_value1),
      .out_q_value2     (out_q_value2),
      .out_commit_reg   (out_commit_reg),
      .out_commit_rob   (out_commit_rob),
      .out_commit_value (out_commit_value),
      .out_xbp          (out_xbp),
      .out_xbp_pc       (out_xbp_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_disp_valid    = 1'b0;
      in_disp_dest_reg = '0;
      in_disp_is_br    = 1'b0;
      in_disp_pred     = 1'b0;
      in_cdb_valid     = 1'b0;
      in_cdb_rob       = '0;
      in_cdb_value     = '0;
      in_cdb_taken     = 1'b0;
      in_cdb_target    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rdy = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic dispatch(input logic [4:0] dest, input logic is_br, input logic pred);
      in_disp_valid    = 1'b1;
      in_disp_dest_reg = dest;
      in_disp_is_br    = is_br;
      in_disp_pred     = pred;
      step();
      in_disp_valid    = 1'b0;
      in_disp_is_br    = 1'b0;
      in_disp_pred     = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                      input logic taken, input logic [31:0] tgt);
      in_cdb_valid  = 1'b1;
      in_cdb_rob    = tag;
      in_cdb_value  = val;
      in_cdb_taken  = taken;
      in_cdb_target = tgt;
      step();
      in_cdb_valid  = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rdy       = 1'b1;
      rst       = 1'b1;
      in_q_rob1 = '0;
      in_q_rob2 = '0;
      step();
      step();
      rst = 1'b0;

      // reset state
      chk("rst_full",     out_full,       0);
      chk("rst_disp_rob", out_disp_rob,   0);
      chk("rst_commit",   out_commit_reg, 0);
      chk("rst_xbp",      out_xbp,        0);
      chk("rst_xbp_pc",   out_xbp_pc,     0);

      // single dispatch / result / commit
      dispatch(5'd5, 1'b0, 1'b0);
      chk("t1_disp_rob", out_disp_rob, 1);
      cdb(4'd0, 32'h1234, 1'b0, 32'h0);
      chk("t1_no_bypass", out_commit_reg, 0);
      step();
      chk("t1_reg",   out_commit_reg,   5);
      chk("t1_rob",   out_commit_rob,   0);
      chk("t1_value", out_commit_value, 32'h1234);
      step();
      chk("t1_idle",  out_commit_reg,   0);

      // out-of-order results retire in order
      do_reset();
      dispatch(5'd10, 1'b0, 1'b0);
      dispatch(5'd11, 1'b0, 1'b0);
      dispatch(5'd12, 1'b0, 1'b0);
      chk("t2_disp_rob", out_disp_rob, 3);
      cdb(4'd2, 32'h22, 1'b0, 32'h0);
      chk("t2_wait2", out_commit_reg, 0);
      cdb(4'd1, 32'h11, 1'b0, 32'h0);
      chk("t2_wait1", out_commit_reg, 0);
      cdb(4'd0, 32'hA0, 1'b0, 32'h0);
      chk("t2_wait0", out_commit_reg, 0);
      step();
      chk("t2_c0_reg", out_commit_reg, 10);
      chk("t2_c0_rob", out_commit_rob, 0);
      chk("t2_c0_val", out_commit_value, 32'hA0);
      step();
      chk("t2_c1_reg", out_commit_reg, 11);
      chk("t2_c1_rob", out_commit_rob, 1);
      chk("t2_c1_val", out_commit_value, 32'h11);
      step();
      chk("t2_c2_reg", out_commit_reg, 12);
      chk("t2_c2_rob", out_commit_rob, 2);
      chk("t2_c2_val", out_commit_value, 32'h22);
      step();
      chk("t2_idle", out_commit_reg, 0);

      // fill, overflow, commit, wrap
      do_reset();
      for (int i = 0; i < 15; i++) dispatch(5'(i + 1), 1'b0, 1'b0);
      chk("t3_not_full15", out_full, 0);
      chk("t3_tail15", out_disp_rob, 15);
      dispatch(5'd16, 1'b0, 1'b0);
      chk("t3_full16", out_full, 1);
      chk("t3_tail_wrap", out_disp_rob, 0);
      dispatch(5'd20, 1'b0, 1'b0);
      chk("t3_17_ignored", out_disp_rob, 0);
      chk("t3_still_full", out_full, 1);
      cdb(4'd0, 32'h55, 1'b0, 32'h0);
      chk("t3_full_wait", out_full, 1);
      step();
      chk("t3_c_reg", out_commit_reg, 1);
      chk("t3_c_rob", out_commit_rob, 0);
      chk("t3_full_drop", out_full, 0);
      dispatch(5'd21, 1'b0, 1'b0);
      chk("t3_reuse_tail", out_disp_rob, 1);
      chk("t3_refull", out_full, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t3_rst_full", out_full, 0);
      chk("t3_rst_tail", out_disp_rob, 0);

      // mispredicted branch flush
      do_reset();
      dispatch(5'd0, 1'b1, 1'b0);
      dispatch(5'd7, 1'b0, 1'b0);
      cdb(4'd1, 32'h9, 1'b0, 32'h0);
      cdb(4'd0, 32'h0, 1'b1, 32'h80);
      chk("t4_pre_xbp", out_xbp, 0);
      step();
      chk("t4_xbp", out_xbp, 1);
      chk("t4_xbp_pc", out_xbp_pc, 32'h80);
      chk("t4_c_reg", out_commit_reg, 0);
      chk("t4_tail0", out_disp_rob, 0);
      chk("t4_full", out_full, 0);
      in_q_rob1 = 4'd1;
      #1;
      chk("t4_entry1_cleared", out_q_ready1, 0);
      step();
      chk("t4_xbp_pulse", out_xbp, 0);
      chk("t4_no_commit", out_commit_reg, 0);

      // correctly predicted branch: no flush, no regfile write
      dispatch(5'd0, 1'b1, 1'b1);
      cdb(4'd0, 32'h0, 1'b1, 32'h44);
      step();
      chk("t5_xbp", out_xbp, 0);
      chk("t5_rob", out_commit_rob, 0);
      chk("t5_reg", out_commit_reg, 0);
      chk("t5_tail", out_disp_rob, 1);

      // query with same-cycle CDB forward
      do_reset();
      for (int i = 0; i < 4; i++) dispatch(5'(i + 1), 1'b0, 1'b0);
      in_q_rob1 = 4'd3;
      in_q_rob2 = 4'd2;
      #1;
      chk("t6_q1_notready", out_q_ready1, 0);
      in_cdb_valid = 1'b1;
      in_cdb_rob   = 4'd3;
      in_cdb_value = 32'h7;
      #1;
      chk("t6_fwd_ready", out_q_ready1, 1);
      chk("t6_fwd_value", out_q_value1, 32'h7);
      chk("t6_q2_notready", out_q_ready2, 0);
      step();
      in_cdb_valid = 1'b0;
      #1;
      chk("t6_stored_ready", out_q_ready1, 1);
      chk("t6_stored_value", out_q_value1, 32'h7);
      in_cdb_valid = 1'b1;
      in_cdb_rob   = 4'd2;
      in_cdb_value = 32'h9;
      #1;
      chk("t6_q2_fwd", out_q_value2, 32'h9);
      chk("t6_q1_keep", out_q_value1, 32'h7);
      in_cdb_valid = 1'b0;

      // rdy low freezes everything
      do_reset();
      dispatch(5'd6, 1'b0, 1'b0);
      dispatch(5'd8, 1'b0, 1'b0);
      cdb(4'd0, 32'h66, 1'b0, 32'h0);
      cdb(4'd1, 32'h88, 1'b0, 32'h0);
      chk("t7_c0_reg", out_commit_reg, 6);
      rdy = 1'b0;
      in_disp_valid    = 1'b1;
      in_disp_dest_reg = 5'd9;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t7_hold_reg", out_commit_reg, 6);
         chk("t7_hold_tail", out_disp_rob, 2);
      end
      in_disp_valid = 1'b0;
      chk("t7_hold_rob", out_commit_rob, 0);
      rdy = 1'b1;
      step();
      chk("t7_c1_reg", out_commit_reg, 8);
      chk("t7_c1_rob", out_commit_rob, 1);
      chk("t7_c1_val", out_commit_value, 32'h88);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
